// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial stage with one-word holding buffer
// Feeds the sequence detector one bit per clk; back-to-back words stream without gaps.
module bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             buf_full, buf_full_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             accept;

  function automatic logic emit(input logic [WIDTH-1:0] s);
    return (MSB_FIRST != 0) ? s[WIDTH-1] : s[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    return (MSB_FIRST != 0) ? {s[WIDTH-2:0], 1'b0} : {1'b0, s[WIDTH-1:1]};
  endfunction

  assign in_ready = ~buf_full;
  assign busy     = (state == SHIFT) | buf_full;
  assign accept   = in_valid & ~buf_full;

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    hold_n     = hold;
    buf_full_n = buf_full;
    cnt_n      = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          shreg_n = in_data;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          // Buffered word wins over the input port so ordering is preserved.
          cnt_n = '0;
          if (buf_full) begin
            shreg_n    = hold;
            buf_full_n = 1'b0;
          end else if (accept) begin
            shreg_n = in_data;
          end else begin
            state_n = IDLE;
          end
        end else begin
          shreg_n = advance(shreg);
          cnt_n   = cnt + 1'b1;
          if (accept) begin
            hold_n     = in_data;
            buf_full_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      hold      <= '0;
      buf_full  <= 1'b0;
      cnt       <= '0;
      x         <= IDLE_BIT;
      x_valid   <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      hold      <= hold_n;
      buf_full  <= buf_full_n;
      cnt       <= cnt_n;
      // Outputs are registered from the next-state view so x lines up with shreg.
      x         <= (state_n == SHIFT) ? emit(shreg_n) : IDLE_BIT;
      x_valid   <= (state_n == SHIFT);
      word_done <= (state_n == SHIFT) && (cnt_n == LAST);
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - directed self-checking bench for bit_serializer
// Two instances share clk/rst: dut (MSB first) and dut_lsb (LSB first).
module tb_bit_serializer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, x, x_valid, word_done, busy;
  logic [7:0] l_data = '0;
  logic       l_valid = 1'b0;
  logic       l_ready, l_x, l_x_valid, l_word_done, l_busy;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .x_valid(x_valid), .word_done(word_done), .busy(busy)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(l_data), .in_valid(l_valid), .in_ready(l_ready),
    .x(l_x), .x_valid(l_x_valid), .word_done(l_word_done), .busy(l_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b0;
    tick();
    in_data = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL reset_x_valid got=%b exp=0", x_valid); end
    checks++; if (x !== 1'b0) begin errors++; $display("FAIL reset_x got=%b exp=0", x); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0 || word_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, word_done); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    w = 8'hB0;
    in_data = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (x !== w[7-i] || x_valid !== 1'b1 || word_done !== (i == 7)) begin
        errors++;
        $display("FAIL single_bit%0d got x=%b v=%b d=%b exp x=%b v=1 d=%b", i, x, x_valid, word_done, w[7-i], (i == 7));
      end
      tick();
    end
    checks++;
    if (x !== 1'b0 || x_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_after got x=%b v=%b busy=%b exp 0 0 0", x, x_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] s;
    logic        exp_rdy;
    s = {8'hA5, 8'h3C, 8'hFF};
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_data = 8'h3C;
    for (int i = 0; i < 24; i++) begin
      if (i == 1) in_data = 8'hFF;
      if (i == 9) in_valid = 1'b0;
      exp_rdy = (i == 0) || (i == 8) || (i >= 16);
      checks++;
      if (x !== s[23-i] || x_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_bit%0d got x=%b v=%b exp x=%b v=1", i, x, x_valid, s[23-i]);
      end
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL b2b_ready%0d got=%b exp=%b", i, in_ready, exp_rdy);
      end
      tick();
    end
    checks++;
    if (x_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_end got v=%b busy=%b exp 0 0", x_valid, busy);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp_bits;
    exp_bits = 8'b1000_0000;
    l_data = 8'h01; l_valid = 1'b1;
    tick();
    l_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (l_x !== exp_bits[7-i] || l_x_valid !== 1'b1 || l_word_done !== (i == 7)) begin
        errors++;
        $display("FAIL lsb_bit%0d got x=%b v=%b d=%b exp x=%b v=1 d=%b", i, l_x, l_x_valid, l_word_done, exp_bits[7-i], (i == 7));
      end
      tick();
    end
    checks++;
    if (l_x_valid !== 1'b0) begin errors++; $display("FAIL lsb_end got v=%b exp 0", l_x_valid); end
  endtask

  task automatic test_reset_mid_word();
    int stray;
    in_data = 8'hFF; in_valid = 1'b1;
    tick();
    in_data = 8'h0F;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (x_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_setup got v=%b rdy=%b exp v=1 rdy=0", x_valid, in_ready);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (x_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got v=%b rdy=%b exp v=0 rdy=1", x_valid, in_ready);
    end
    tick();
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (x_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL mid_stale got=%0d stray cycles exp=0", stray); end
  endtask

  task automatic test_detector();
    logic [2:0] hist;
    int bitno, hits, first_hit, second_hit, budget;
    hist = '0; bitno = 0; hits = 0; first_hit = 0; second_hit = 0;
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    budget = 0;
    while (x_valid === 1'b1 && budget < 20) begin
      hist = {hist[1:0], x};
      bitno++;
      if (bitno >= 3 && hist == 3'b101) begin
        hits++;
        if (hits == 1) first_hit = bitno;
        if (hits == 2) second_hit = bitno;
      end
      budget++;
      tick();
    end
    checks++;
    if (bitno != 8) begin errors++; $display("FAIL det_len got=%0d exp=8", bitno); end
    checks++;
    if (hits != 2 || first_hit != 3 || second_hit != 8) begin
      errors++; $display("FAIL det_hits got n=%0d at %0d,%0d exp n=2 at 3,8", hits, first_hit, second_hit);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid_word();
    test_detector();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
